// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register file geometry and the writeback opcodes.
// Opcodes let the writeback stage decide whether an instruction produces a register write.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int NREGS      = 8;
  localparam int REG_ADDR_W = $clog2(NREGS);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_LI  = 3'b111;

  typedef logic [NREGS-1:0][DATA_W-1:0] reg_view_t;

  // Stores and branches retire without touching the register file.
  function automatic logic op_writes_reg(input logic [2:0] op);
    return (op != OP_SW) && (op != OP_BEQ);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with r0 forced to zero and same-edge write-through; latency 1 cycle.
// hold freezes the output register; the caller folds halt and stall into it.
import cpu_pkg::*;

module regfile_read_port (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic [REG_ADDR_W-1:0] addr,
  input  reg_view_t             regs,
  input  logic                  wr_commit,
  input  logic [REG_ADDR_W-1:0] wr_tgt,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] rd_next;

  always_comb begin
    rd_next = regs[addr];
    if (addr == '0)
      rd_next = '0;
    else if (wr_commit && (wr_tgt == addr))
      rd_next = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (!hold)
      rd_data <= rd_next;
  end

endmodule

// File: rtl/regfile.sv
// 8x16 register file, r0 reads zero, two 1-cycle read ports with write-through, wrapping write counter.
// halt freezes everything; stall holds read data only. REGFILE_DEBUG_PORT_EN adds a combinational peek port.
import cpu_pkg::*;

module regfile (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wr_tgt,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0]     ra_data,
  output logic [DATA_W-1:0]     rb_data,
  output logic [DATA_W-1:0]     wr_count
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
`endif
);

  reg_view_t regs;
  logic      wr_commit;
  logic      rd_hold;

  assign wr_commit = we && !halt && (wr_tgt != '0);
  assign rd_hold   = halt || stall;

  // Entry 0 is reset and never written, so it stays a constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_commit && (wr_tgt == REG_ADDR_W'(i)))
          regs[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_count <= '0;
    else if (wr_commit)
      wr_count <= wr_count + 1'b1;
  end

  regfile_read_port u_port_a (
    .clk       (clk),
    .rst       (rst),
    .hold      (rd_hold),
    .addr      (ra_addr),
    .regs      (regs),
    .wr_commit (wr_commit),
    .wr_tgt    (wr_tgt),
    .wr_data   (wr_data),
    .rd_data   (ra_data)
  );

  regfile_read_port u_port_b (
    .clk       (clk),
    .rst       (rst),
    .hold      (rd_hold),
    .addr      (rb_addr),
    .regs      (regs),
    .wr_commit (wr_commit),
    .wr_tgt    (wr_tgt),
    .wr_data   (wr_data),
    .rd_data   (rb_data)
  );

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule
